// File: rtl/mips_avalon_pkg.sv
// Shared types and constants for the Avalon-MM slave memory model.
package mips_avalon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    RESP  = 2'd2
  } slave_state_t;

  localparam logic [31:0] DEADBEEF   = 32'hDEAD_BEEF;
  localparam int          CNT_W      = 8;
  localparam logic [7:0]  LFSR_TAPS  = 8'hB8;  // x^8 + x^6 + x^5 + x^4 + 1

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        rd;
    logic        wr;
  } bus_req_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mips_lfsr8.sv
// 8-bit Galois LFSR used to randomise the stall length of each access.
module mips_lfsr8
  import mips_avalon_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  input  logic [7:0] seed,
  output logic [7:0] value
);

  logic [7:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (advance) value_d = {1'b0, value_q[7:1]} ^ (value_q[0] ? LFSR_TAPS : 8'h00);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) value_q <= seed;
    else      value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/mips_avalon_slave_mem.sv
// Avalon-MM slave RAM with programmable/random waitrequest stalls and a sticky
// protocol error flag; serves as the main memory behind the CPU data bus.
module mips_avalon_slave_mem
  import mips_avalon_pkg::*;
#(
  parameter int unsigned MEM_WORDS    = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'hBFC0_0000,
  parameter int unsigned STALL_CYCLES = 2,
  parameter bit          RANDOM_STALL = 1'b0,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        err,
  output logic [1:0]  state_out
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  slave_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, stall_n;
  bus_req_t         cur_req, lat_q, lat_d;
  logic             err_q, err_d;
  logic             req, accept, wait_int, addr_ok, mem_we;
  logic [31:0]      off;
  logic [IDX_W-1:0] idx;
  logic [7:0]       lfsr_val;
  logic             unused_bits;
  logic [31:0]      mem_q [MEM_WORDS];

  assign req     = read | write;
  assign cur_req = {address, writedata, byteenable, read, write};
  assign off     = address - BASE_ADDR;
  assign idx     = off[IDX_W+1:2];
  assign addr_ok = (address >= BASE_ADDR) && (off[31:IDX_W+2] == '0) && (address[1:0] == 2'b00);
  assign stall_n = CNT_W'(STALL_CYCLES) + (RANDOM_STALL ? CNT_W'(lfsr_val[1:0]) : CNT_W'(0));
  assign unused_bits = ^{lfsr_val, off[1:0]};

  mips_lfsr8 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .advance (accept),
    .seed    (LFSR_SEED),
    .value   (lfsr_val)
  );

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lat_d    = lat_q;
    err_d    = err_q;
    wait_int = req;
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (stall_n == '0) begin
            wait_int = 1'b0;
            accept   = 1'b1;
          end else begin
            lat_d   = cur_req;
            cnt_d   = stall_n - CNT_W'(1);
            state_d = (stall_n == CNT_W'(1)) ? RESP : STALL;
          end
        end
      end
      STALL: begin
        if (!req) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          if (cur_req != lat_q) err_d = 1'b1;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (!req) begin
          err_d = 1'b1;
        end else begin
          wait_int = 1'b0;
          accept   = 1'b1;
          if (cur_req != lat_q) err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Bad address or simultaneous read+write still completes, only flags the error.
    if (accept && ((read && write) || !addr_ok)) err_d = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      err_q   <= err_d;
    end
  end

  assign mem_we = rst && accept && write && addr_ok;

  // NOTE: the RAM array is deliberately not reset; contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= merge_bytes(mem_q[idx], writedata, byteenable);
  end

  always_comb begin
    readdata = '0;
    if (rst && read && !wait_int) readdata = addr_ok ? mem_q[idx] : DEADBEEF;
  end

  assign waitrequest = rst ? wait_int : req;
  assign err         = err_q;
  assign state_out   = state_q;

endmodule

// File: tb/tb_mips_avalon_slave_mem.sv
// Scoreboard bench: three slave instances (2-cycle, zero-wait, random stall).
module tb_mips_avalon_slave_mem;

  localparam logic [31:0] BASE = 32'hBFC0_0000;
  localparam int NDUT = 3;

  typedef struct { int d; logic [31:0] data; } exp_t;

  logic        clk = 1'b0;
  logic        rst_n [NDUT];
  logic [31:0] addr  [NDUT];
  logic [31:0] wdata [NDUT];
  logic [31:0] rdata [NDUT];
  logic [3:0]  be    [NDUT];
  logic        rd    [NDUT];
  logic        wr    [NDUT];
  logic        wreq  [NDUT];
  logic        err   [NDUT];
  logic [1:0]  st    [NDUT];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          last_waits;
  int          c0;
  exp_t        sb_q [$];
  exp_t        mon_e;
  logic [31:0] model [16];
  logic [3:0]  seen;
  logic [3:0]  r_idx, r_be;
  logic [31:0] r_dat;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mips_avalon_slave_mem #(
      .STALL_CYCLES ((g == 1) ? 0 : 2),
      .RANDOM_STALL (g == 2)
    ) u_dut (
      .clk         (clk),
      .rst         (rst_n[g]),
      .address     (addr[g]),
      .read        (rd[g]),
      .write       (wr[g]),
      .writedata   (wdata[g]),
      .byteenable  (be[g]),
      .waitrequest (wreq[g]),
      .readdata    (rdata[g]),
      .err         (err[g]),
      .state_out   (st[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_tests++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req_v);
    end
  endtask

  // Monitor: every accepted pure read is compared against the scoreboard head.
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (rst_n[d] && rd[d] && !wr[d] && !wreq[d]) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_read", 32'(sb_q.size()), 32'd1);
        end else begin
          mon_e = sb_q.pop_front();
          check("sb_dut", 32'(d), 32'(mon_e.d));
          check("sb_rdata", rdata[d], mon_e.data);
        end
      end
    end
  end

  task automatic idle(input int d);
    rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wdata[d] = '0; be[d] = '0;
  endtask

  task automatic access(input int d, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] b, input logic [31:0] exp_rd,
                        input int exp_wait, input string name);
    int waits;
    waits = 0;
    rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
    if (r && !w) sb_q.push_back('{d, exp_rd});
    @(negedge clk);
    while (wreq[d] && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (wreq[d]) check({name, "_timeout"}, 32'(wreq[d]), 32'd0);
    if (exp_wait >= 0) check({name, "_wait"}, 32'(waits), 32'(exp_wait));
    last_waits = waits;
    @(posedge clk); #1;
  endtask

  task automatic wr_word(input int d, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] b, input int ew, input string name);
    access(d, 1'b0, 1'b1, a, wd, b, 32'h0, ew, name);
  endtask

  task automatic rd_word(input int d, input logic [31:0] a, input logic [31:0] exp_v,
                         input int ew, input string name);
    access(d, 1'b1, 1'b0, a, 32'h0, 4'h0, exp_v, ew, name);
  endtask

  task automatic expect_err(input int d, input logic v, input string name);
    idle(d);
    @(negedge clk);
    check(name, 32'(err[d]), 32'(v));
    check({name, "_state"}, 32'(st[d]), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset(input int d);
    rst_n[d] = 1'b0;
    @(posedge clk); #1;
    rst_n[d] = 1'b1;
  endtask

  task automatic stall_range(input string name);
    check(name, 32'(last_waits >= 2 && last_waits <= 5), 32'd1);
    if (last_waits >= 2 && last_waits <= 5) seen[last_waits-2] = 1'b1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] b);
    logic [31:0] res;
    res = o;
    for (int i = 0; i < 4; i++) if (b[i]) res[8*i +: 8] = n[8*i +: 8];
    return res;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    seen = '0;
    for (int d = 0; d < NDUT; d++) begin
      rst_n[d] = 1'b0;
      idle(d);
    end
    rd[1] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_wait_follows_req", 32'(wreq[1]), 32'd1);
    check("rst_rdata_zero", rdata[1], 32'd0);
    check("rst_state", 32'(st[0]), 32'd0);
    check("rst_err", 32'(err[0]), 32'd0);
    rd[1] = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < NDUT; d++) rst_n[d] = 1'b1;
    @(negedge clk);
    check("post_rst_wait", 32'(wreq[0]), 32'd0);
    @(posedge clk); #1;

    // Two-cycle stall instance: full and partial byte writes, boundaries.
    wr_word(0, BASE, 32'h1234_5678, 4'hF, 2, "wr_full");
    rd_word(0, BASE, 32'h1234_5678, 2, "rd_full");
    wr_word(0, BASE, 32'hAABB_CCDD, 4'b0101, 2, "wr_be5");
    rd_word(0, BASE, 32'h12BB_56DD, 2, "rd_be5");
    wr_word(0, BASE, 32'hFFFF_FFFF, 4'b0000, 2, "wr_be0");
    rd_word(0, BASE, 32'h12BB_56DD, 2, "rd_be0");
    wr_word(0, BASE + 32'd4092, 32'hA5A5_0FF0, 4'hF, 2, "wr_last");
    rd_word(0, BASE + 32'd4092, 32'hA5A5_0FF0, 2, "rd_last");
    expect_err(0, 1'b0, "err_clean");

    rd_word(0, BASE - 32'd4, 32'hDEAD_BEEF, 2, "rd_below");
    expect_err(0, 1'b1, "err_below");
    pulse_reset(0);
    rd_word(0, BASE, 32'h12BB_56DD, 2, "rd_after_rst");
    expect_err(0, 1'b0, "err_cleared");
    rd_word(0, BASE + 32'd2, 32'hDEAD_BEEF, 2, "rd_misal");
    expect_err(0, 1'b1, "err_misal");
    pulse_reset(0);
    wr_word(0, BASE + 32'd4096, 32'h0000_0001, 4'hF, 2, "wr_above");
    expect_err(0, 1'b1, "err_above");
    pulse_reset(0);
    rd_word(0, BASE, 32'h12BB_56DD, 2, "rd_above_dropped");
    access(0, 1'b1, 1'b1, BASE + 32'd8, 32'h0BAD_F00D, 4'hF, 32'h0, 2, "rw_both");
    expect_err(0, 1'b1, "err_rw_both");
    pulse_reset(0);
    rd_word(0, BASE + 32'd8, 32'h0BAD_F00D, 2, "rd_rw_both");

    // Address moved while stalled: the value present in the response cycle wins.
    wr[0] = 1'b1; addr[0] = BASE + 32'd12; wdata[0] = 32'h1111_1111; be[0] = 4'hF;
    @(posedge clk); #1;
    addr[0] = BASE + 32'd16;
    @(negedge clk);
    check("chg_stalled", 32'(wreq[0]), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("chg_accepted", 32'(wreq[0]), 32'd0);
    @(posedge clk); #1;
    expect_err(0, 1'b1, "err_addr_chg");
    pulse_reset(0);
    rd_word(0, BASE + 32'd16, 32'h1111_1111, 2, "rd_chg_committed");

    // Request withdrawn mid-stall.
    rd[0] = 1'b1; addr[0] = BASE;
    @(posedge clk); #1;
    idle(0);
    @(posedge clk); #1;
    expect_err(0, 1'b1, "err_drop");
    pulse_reset(0);

    // Zero-wait instance: four back-to-back writes in four cycles.
    c0 = cyc;
    for (int i = 0; i < 4; i++)
      wr_word(1, BASE + 32'(4*i), 32'hC0DE_0000 + 32'(i), 4'hF, 0, "b2b_wr");
    check("b2b_cycles", 32'(cyc - c0), 32'd4);
    for (int i = 0; i < 4; i++)
      rd_word(1, BASE + 32'(4*i), 32'hC0DE_0000 + 32'(i), 0, "b2b_rd");
    expect_err(1, 1'b0, "err_b2b");

    // Random-stall instance: 200 accesses against a word model.
    for (int i = 0; i < 16; i++) begin
      model[i] = $urandom;
      wr_word(2, BASE + 32'(4*i), model[i], 4'hF, -1, "rnd_init");
      stall_range("rnd_stall_range");
    end
    for (int i = 0; i < 184; i++) begin
      r_idx = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) begin
        rd_word(2, BASE + 32'(4*r_idx), model[r_idx], -1, "rnd_rd");
      end else begin
        r_dat = $urandom;
        r_be  = 4'($urandom_range(0, 15));
        wr_word(2, BASE + 32'(4*r_idx), r_dat, r_be, -1, "rnd_wr");
        model[r_idx] = merge(model[r_idx], r_dat, r_be);
      end
      stall_range("rnd_stall_range");
    end
    check("rnd_stall_spread", 32'(seen), 32'hF);
    expect_err(2, 1'b0, "err_rnd");

    // Reset in the middle of a stalled write: access abandoned, RAM untouched.
    wr[2] = 1'b1; addr[2] = BASE + 32'd12; wdata[2] = ~model[3]; be[2] = 4'hF;
    @(negedge clk);
    check("mid_wait_high", 32'(wreq[2]), 32'd1);
    @(posedge clk); #1;
    rst_n[2] = 1'b0;
    #1;
    check("mid_rst_wait", 32'(wreq[2]), 32'd1);
    check("mid_rst_state", 32'(st[2]), 32'd0);
    check("mid_rst_rdata", rdata[2], 32'd0);
    idle(2);
    #1;
    check("mid_rst_wait_idle", 32'(wreq[2]), 32'd0);
    @(posedge clk); #1;
    rst_n[2] = 1'b1;
    rd_word(2, BASE + 32'd12, model[3], -1, "rd_mid_rst");
    stall_range("mid_rst_stall_range");
    expect_err(2, 1'b0, "err_mid_rst");

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
